inv_key_sched: RTL

//  Inverse AES-128 key schedule: walks the key expansion backwards, round key 10 down to round key 0.

---
 rtl/inv_key_sched_if.sv | 23 ++
 rtl/inv_key_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched_if.sv
// Handshake bundle for the inverse AES-128 key schedule: walk control in, round-key stream out.
interface inv_key_sched_if #(
  parameter int KEY_LEN = 128
);
  logic               start;
  logic [KEY_LEN-1:0] last_key;
  logic [KEY_LEN-1:0] key_out;
  logic [3:0]         key_round;
  logic               key_valid;
  logic               key_ready;
  logic               busy;
  logic               done;

  modport master (
    input  start, last_key, key_ready,
    output key_out, key_round, key_valid, busy, done
  );

  modport slave (
    output start, last_key, key_ready,
    input  key_out, key_round, key_valid, busy, done
  );
endinterface

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key schedule: emits round keys 10 down to 0, one per valid/ready handshake,
// recomputing each previous key with a single shared, registered SubWord stage.
module inv_key_sched #(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  inv_key_sched_if.master bus
);

  if (KEY_LEN != 128 || WORD_LEN != 32) begin : g_bad_len
    $error("inv_key_sched supports only KEY_LEN=128 and WORD_LEN=32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_LEN-1:0] sub_word(input logic [WORD_LEN-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t              state_r;
  logic [KEY_LEN-1:0]  key_reg_r;
  logic [3:0]          round_r;
  logic                key_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                sub_valid_r;
  logic [WORD_LEN-1:0] sub_word_r;

  logic                handshake_s;
  logic                launch_s;
  logic [WORD_LEN-1:0] w0_s, w1_s, w2_s, w3_s;
  logic [WORD_LEN-1:0] rot_s;
  logic [KEY_LEN-1:0]  prev_key_s;

  // Inverse step on the held key {w4..w7}: recover {w0..w3} using the registered SubWord result.
  always_comb begin
    handshake_s = (state_r == EMIT) && bus.key_ready;
    launch_s    = handshake_s && (round_r != 4'd0);
    w3_s        = key_reg_r[31:0]   ^ key_reg_r[63:32];
    w2_s        = key_reg_r[63:32]  ^ key_reg_r[95:64];
    w1_s        = key_reg_r[95:64]  ^ key_reg_r[127:96];
    rot_s       = {w3_s[23:0], w3_s[31:24]};
    w0_s        = key_reg_r[127:96] ^ sub_word_r ^ {rcon(round_r), 24'h000000};
    prev_key_s  = {w0_s, w1_s, w2_s, w3_s};
  end

  // Shared SubWord stage: one-cycle registered latency, launched on a non-final handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_valid_r <= 1'b0;
      sub_word_r  <= {WORD_LEN{1'b0}};
    end else begin
      sub_valid_r <= launch_s;
      if (launch_s) sub_word_r <= sub_word(rot_s);
      else          sub_word_r <= sub_word_r;
    end
  end

  // Walk controller: IDLE -> EMIT (present key) -> SUB (rebuild previous key) -> EMIT ... -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      key_reg_r   <= {KEY_LEN{1'b0}};
      round_r     <= 4'd0;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            key_reg_r   <= bus.last_key;
            round_r     <= 4'd10;
            key_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= EMIT;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (handshake_s) begin
            key_valid_r <= 1'b0;
            if (round_r == 4'd0) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= SUB;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        SUB: begin
          if (sub_valid_r) begin
            key_reg_r   <= prev_key_s;
            round_r     <= round_r - 4'd1;
            key_valid_r <= 1'b1;
            state_r     <= EMIT;
          end else begin
            state_r <= SUB;
          end
        end
        default: begin
          key_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_out   = key_reg_r;
  assign bus.key_round = round_r;
  assign bus.key_valid = key_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule
